instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Front end of the MIPS pipeline, directly upstream of the combinational Instruction_memory.
- Owns the program counter and drives the memory address. Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect from later stages, and detects fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_TOP, 32'h0000_FFFC, highest legal word address (64 KB instruction memory).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard stall: hold PC and IF/ID contents.
- flush  input  1  squash the IF/ID entry being written this cycle.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  32  new PC when redirect_valid=1.
- imem_addr  output  32  address to instruction memory; equals pc.
- imem_instr  input  32  instruction returned combinationally for imem_addr.
- ifid_instr  output  32  latched instruction (32'h0 NOP on bubble).
- ifid_pc  output  32  PC of ifid_instr.
- ifid_pc_plus4  output  32  ifid_pc+4.
- ifid_valid  output  1  IF/ID entry holds a real instruction.
- fetch_fault  output  1  sticky fault flag.
- fault_pc  output  32  offending PC, captured on fault entry.
- fetch_count  output  32  number of instructions latched with valid=1.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - pc=RESET_PC, state=BOOT.
  - ifid_instr=0, ifid_pc=0, ifid_pc_plus4=0, ifid_valid=0.
  - fetch_fault=0, fault_pc=0, fetch_count=0.
- Reset asserted mid-operation discards all state immediately; no partial IF/ID update survives.
- Memory path: imem_addr=pc, combinational. imem_instr is sampled at the same rising edge, so there is zero extra wait cycles and one-cycle latency from PC to IF/ID.
- Fault condition (checked on the current pc): pc[1:0]!=0 or pc>IMEM_TOP.
- FSM states:
  - BOOT: single cycle after reset release. No IF/ID write; ifid_valid stays 0; pc holds. Next state is RUN unconditionally.
  - RUN: normal fetch, per-edge priority below.
  - FAULT: sticky until reset. ifid_valid=0, ifid_instr=0; pc, fetch_count and fault_pc frozen. All inputs ignored; fetch_fault=1.
- RUN, per rising edge, highest priority first:
  1. Current pc faulty: enter FAULT, fault_pc<=pc, write IF/ID bubble. Overrides redirect, stall and flush.
  2. redirect_valid=1: pc<=redirect_target, write IF/ID bubble. Overrides stall; the faulty-target check happens on the next edge.
  3. stall=1 and flush=1: pc holds, write IF/ID bubble.
  4. stall=1: pc holds, all IF/ID outputs hold, fetch_count holds.
  5. flush=1: pc<=pc+4, write IF/ID bubble.
  6. Otherwise:
     - ifid_instr<=imem_instr, ifid_pc<=pc, ifid_pc_plus4<=pc+4, ifid_valid<=1.
     - pc<=pc+4.
     - fetch_count<=fetch_count+1.
- Bubble definition: ifid_instr=0, ifid_valid=0, ifid_pc/ifid_pc_plus4 hold previous values. fetch_count does not increment.
- Arithmetic: pc+4 is modulo 2^32 (wraps silently; the fault check catches out-of-range). fetch_count is modulo 2^32.
- No combinational path from stall/flush/redirect to imem_addr; imem_addr changes only on a clock edge or on reset.

Test Plan:
- Reset then free-run with IM holding 0x20080001, 0x20090002, 0x01095020 at words 0..2. Required response:
  - Cycle after release: ifid_valid=0 (BOOT).
  - Then ifid_instr = 0x20080001/0x20090002/0x01095020 with ifid_pc = 0/4/8.
  - fetch_count = 3, imem_addr = 0xC.
- Stall for 2 cycles at pc=8 → imem_addr stays 8 and IF/ID unchanged for 2 cycles. After release: ifid_pc=8 and fetch_count increments exactly once.
- Redirect to 0x40 with stall=1 at pc=0xC → next edge: pc=0x40, ifid_valid=0, fetch_count unchanged. Following edge: ifid_pc=0x40 with valid=1.
- Flush alone at pc=0x10 → ifid_valid=0, ifid_instr=0, pc=0x14. Flush+stall at pc=0x14 → bubble with pc held at 0x14.
- Redirect to 0x42 → one edge later: fetch_fault=1, fault_pc=0x42, ifid_valid=0. A further redirect to 0x0 is ignored. Asserting rst_n=0 asynchronously clears the fault and restores pc=RESET_PC.
- Redirect to 0x0001_0000 → FAULT with fault_pc=0x0001_0000. Redirect to 0xFFFC → fetch succeeds with ifid_pc=0xFFFC; the next edge faults with fault_pc=0x0001_0000 (pc+4 beyond IMEM_TOP).

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the combinational instruction memory
// and fills the IF/ID pipeline register, handling stall, flush, redirect and fetch faults.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] IMEM_TOP = 32'h0000_FFFC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        fetch_fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_bad;

    assign pc_plus4    = pc + 32'd4;
    assign pc_bad      = (pc[1:0] != 2'b00) || (pc > IMEM_TOP);
    assign imem_addr   = pc;
    assign fetch_fault = (state == FAULT);

    // A fault on the current pc outranks every request from later stages;
    // a redirect outranks stall so a taken branch is never lost behind a hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BOOT;
            pc            <= RESET_PC;
            ifid_instr    <= 32'h0;
            ifid_pc       <= 32'h0;
            ifid_pc_plus4 <= 32'h0;
            ifid_valid    <= 1'b0;
            fault_pc      <= 32'h0;
            fetch_count   <= 32'h0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (pc_bad) begin
                        state      <= FAULT;
                        fault_pc   <= pc;
                        ifid_instr <= 32'h0;
                        ifid_valid <= 1'b0;
                    end else if (redirect_valid) begin
                        pc         <= redirect_target;
                        ifid_instr <= 32'h0;
                        ifid_valid <= 1'b0;
                    end else if (stall && flush) begin
                        ifid_instr <= 32'h0;
                        ifid_valid <= 1'b0;
                    end else if (stall) begin
                        state <= RUN;
                    end else if (flush) begin
                        pc         <= pc_plus4;
                        ifid_instr <= 32'h0;
                        ifid_valid <= 1'b0;
                    end else begin
                        ifid_instr    <= imem_instr;
                        ifid_pc       <= pc;
                        ifid_pc_plus4 <= pc_plus4;
                        ifid_valid    <= 1'b1;
                        pc            <= pc_plus4;
                        fetch_count   <= fetch_count + 32'd1;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed walk through the fetch
// scenarios followed by randomized stall/flush/redirect traffic against a reference model.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int tests_run;
    int tests_failed;

    logic [31:0] mem [0:16383];

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] p4;
        logic [31:0] fpc;
        logic [31:0] cnt;
        logic [31:0] addr;
        logic        valid;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic        m_booting;
    logic        m_faulted;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_p4;
    logic [31:0] m_fpc;
    logic [31:0] m_cnt;
    logic        m_valid;

    instruction_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_pc_plus4   (ifid_pc_plus4),
        .ifid_valid      (ifid_valid),
        .fetch_fault     (fetch_fault),
        .fault_pc        (fault_pc),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_instr = (imem_addr <= 32'h0000_FFFC) ? mem[imem_addr[15:2]] : 32'hDEAD_BEEF;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_booting = 1'b1;
        m_faulted = 1'b0;
        m_pc      = 32'h0;
        m_instr   = 32'h0;
        m_ipc     = 32'h0;
        m_p4      = 32'h0;
        m_fpc     = 32'h0;
        m_cnt     = 32'h0;
        m_valid   = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model by one edge and queue the result.
    task automatic driveAndPush(input logic st, input logic fl, input logic rv, input logic [31:0] rt);
        exp_t e;
        stall           = st;
        flush           = fl;
        redirect_valid  = rv;
        redirect_target = rt;
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_faulted) begin
            m_faulted = 1'b1;
        end else if (m_pc % 4 != 0 || m_pc > 32'h0000_FFFC) begin
            m_faulted = 1'b1;
            m_fpc     = m_pc;
            m_instr   = 32'h0;
            m_valid   = 1'b0;
        end else if (rv) begin
            m_pc    = rt;
            m_instr = 32'h0;
            m_valid = 1'b0;
        end else if (st && fl) begin
            m_instr = 32'h0;
            m_valid = 1'b0;
        end else if (st) begin
            m_valid = m_valid;
        end else if (fl) begin
            m_pc    = m_pc + 4;
            m_instr = 32'h0;
            m_valid = 1'b0;
        end else begin
            m_instr = mem[m_pc / 4];
            m_ipc   = m_pc;
            m_p4    = m_pc + 4;
            m_valid = 1'b1;
            m_pc    = m_pc + 4;
            m_cnt   = m_cnt + 1;
        end
        e.instr = m_instr;
        e.ipc   = m_ipc;
        e.p4    = m_p4;
        e.fpc   = m_fpc;
        e.cnt   = m_cnt;
        e.addr  = m_pc;
        e.valid = m_valid;
        e.fault = m_faulted;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic st, input logic fl, input logic rv, input logic [31:0] rt);
        @(negedge clk);
        driveAndPush(st, fl, rv, rt);
    endtask

    // Asynchronous reset landing mid-cycle; the release edge is followed by the BOOT edge.
    task automatic doReset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_imem_addr", imem_addr, 32'h0);
        checkOutput("rst_ifid_valid", {31'h0, ifid_valid}, 32'h0);
        checkOutput("rst_ifid_instr", ifid_instr, 32'h0);
        checkOutput("rst_ifid_pc", ifid_pc, 32'h0);
        checkOutput("rst_fetch_fault", {31'h0, fetch_fault}, 32'h0);
        checkOutput("rst_fault_pc", fault_pc, 32'h0);
        checkOutput("rst_fetch_count", fetch_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        driveAndPush(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #3;
    endtask

    // Monitor: compare every DUT edge result against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("sb_ifid_instr", ifid_instr, e.instr);
                checkOutput("sb_ifid_pc", ifid_pc, e.ipc);
                checkOutput("sb_ifid_pc_plus4", ifid_pc_plus4, e.p4);
                checkOutput("sb_ifid_valid", {31'h0, ifid_valid}, {31'h0, e.valid});
                checkOutput("sb_fetch_fault", {31'h0, fetch_fault}, {31'h0, e.fault});
                checkOutput("sb_fault_pc", fault_pc, e.fpc);
                checkOutput("sb_fetch_count", fetch_count, e.cnt);
                checkOutput("sb_imem_addr", imem_addr, e.addr);
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        int          r;
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020;
        mem[16383] = 32'h1234_5678;
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        modelReset();
        #12;
        doReset();
        afterEdge();
        checkOutput("boot_valid", {31'h0, ifid_valid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        afterEdge();
        checkOutput("fetch0_instr", ifid_instr, 32'h2008_0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        afterEdge();
        checkOutput("stall_addr", imem_addr, 32'h8);
        checkOutput("stall_ifid_pc", ifid_pc, 32'h4);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        afterEdge();
        checkOutput("fetch2_instr", ifid_instr, 32'h0109_5020);
        checkOutput("fetch2_pc", ifid_pc, 32'h8);
        checkOutput("fetch2_count", fetch_count, 32'd3);
        checkOutput("fetch2_addr", imem_addr, 32'hC);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
        afterEdge();
        checkOutput("redir_addr", imem_addr, 32'h40);
        checkOutput("redir_count", fetch_count, 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        afterEdge();
        checkOutput("redir_fetch_pc", ifid_pc, 32'h40);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h10);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        afterEdge();
        checkOutput("flush_addr", imem_addr, 32'h14);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        afterEdge();
        checkOutput("flushstall_addr", imem_addr, 32'h14);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h42);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        afterEdge();
        checkOutput("mis_fault", {31'h0, fetch_fault}, 32'h1);
        checkOutput("mis_fault_pc", fault_pc, 32'h42);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
        afterEdge();
        checkOutput("fault_sticky_addr", imem_addr, 32'h42);
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0001_0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        afterEdge();
        checkOutput("oor_fault_pc", fault_pc, 32'h0001_0000);
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        afterEdge();
        checkOutput("top_fetch_pc", ifid_pc, 32'h0000_FFFC);
        checkOutput("top_fetch_instr", ifid_instr, 32'h1234_5678);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        afterEdge();
        checkOutput("wrap_fault_pc", fault_pc, 32'h0001_0000);
        doReset();
        for (int c = 0; c < 400; c++) begin
            if (m_faulted && ($urandom_range(0, 3) == 0)) begin
                doReset();
            end else begin
                r = $urandom_range(0, 99);
                tgt = {22'h0, $urandom_range(0, 255), 2'b00};
                if (r < 3) tgt = tgt | 32'h1;
                else if (r < 5) tgt = tgt | 32'h0002_0000;
                applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                              $urandom_range(0, 9) == 0, tgt);
            end
        end
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checkOutput("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
